// File: rtl/bally_video_pkg.sv
// Shared types and default timing for the BALLY video sync recovery stage.
package bally_video_pkg;

   // Frame-lock qualification states.
   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } lock_state_t;

   // Default BALLY timing: 16 video clocks per pixel, 9-bit position counters.
   localparam int DEF_PIX_DIV     = 16;
   localparam int DEF_CNT_W       = 9;
   localparam int DEF_H_ACT_START = 34;
   localparam int DEF_H_ACT_END   = 214;
   localparam int DEF_V_ACT_START = 25;
   localparam int DEF_V_ACT_END   = 254;
   localparam int DEF_LOCK_FRAMES = 2;

   // Width of the matching-frame counter; comfortably covers any sensible LOCK_FRAMES.
   localparam int MATCH_W = 4;

endpackage

// File: rtl/bally_sync_2ff.sv
// Two-flop synchroniser bringing a clk_sys-domain level into the video clock domain.
module bally_sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two back-to-back flops; only the second stage is used downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/bally_video_sync.sv
// Recovers pixel enable, position counters, blanking and frame lock from raw core syncs.
module bally_video_sync
   import bally_video_pkg::*;
#(
   parameter int PIX_DIV     = DEF_PIX_DIV,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int H_ACT_START = DEF_H_ACT_START,
   parameter int H_ACT_END   = DEF_H_ACT_END,
   parameter int V_ACT_START = DEF_V_ACT_START,
   parameter int V_ACT_END   = DEF_V_ACT_END,
   parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
   input  logic             CLK_VIDEO,
   input  logic             reset,
   input  logic             hs_in,
   input  logic             vs_in,
   output logic             ce_pix,
   output logic             hsync,
   output logic             vsync,
   output logic             hblank,
   output logic             vblank,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic [CNT_W-1:0] line_len,
   output logic [CNT_W-1:0] frame_len,
   output logic             locked
);

   localparam int               DIV_W      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PIX_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] H_START    = CNT_W'(H_ACT_START);
   localparam logic [CNT_W-1:0] H_END      = CNT_W'(H_ACT_END);
   localparam logic [CNT_W-1:0] V_START    = CNT_W'(V_ACT_START);
   localparam logic [CNT_W-1:0] V_END      = CNT_W'(V_ACT_END);
   localparam logic [MATCH_W-1:0] MATCH_ZERO = {MATCH_W{1'b0}};
   localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_FRAMES - 1);

   logic               hs_sync_s;
   logic               vs_sync_s;
   logic [DIV_W-1:0]   div_cnt_r;
   logic               tick_s;
   logic               ce_pix_r;
   logic               hsync_r;
   logic               vsync_r;
   logic               hblank_r;
   logic               vblank_r;
   logic [CNT_W-1:0]   hcount_r;
   logic [CNT_W-1:0]   vcount_r;
   logic [CNT_W-1:0]   line_len_r;
   logic [CNT_W-1:0]   frame_len_r;
   logic               locked_r;
   logic               hs_rise_s;
   logic               vs_rise_s;
   logic               timeout_s;
   logic [CNT_W-1:0]   new_len_s;
   logic [CNT_W-1:0]   line_meas_s;
   logic [CNT_W-1:0]   hcount_nxt_s;
   logic [CNT_W-1:0]   vcount_nxt_s;
   lock_state_t        state_r;
   lock_state_t        state_nxt_s;
   logic [MATCH_W-1:0] match_r;
   logic [MATCH_W-1:0] match_nxt_s;
   logic [CNT_W-1:0]   ref_len_r;
   logic [CNT_W-1:0]   ref_len_nxt_s;
   logic               locked_nxt_s;
   logic               hblank_nxt_s;
   logic               vblank_nxt_s;

   bally_sync_2ff u_hs_sync (.clk(CLK_VIDEO), .reset(reset), .d(hs_in), .q(hs_sync_s));
   bally_sync_2ff u_vs_sync (.clk(CLK_VIDEO), .reset(reset), .d(vs_in), .q(vs_sync_s));

   assign tick_s      = (div_cnt_r == DIV_LAST);
   assign hs_rise_s   = hs_sync_s & ~hsync_r;
   // vsync is only resampled on an hsync rising edge, so a frame edge is always a line edge.
   assign vs_rise_s   = hs_rise_s & vs_sync_s & ~vsync_r;
   assign timeout_s   = (vcount_r == CNT_MAX);
   assign new_len_s   = vcount_r + CNT_ONE;
   assign line_meas_s = hcount_r + CNT_ONE;

   // Pixel divider: free-running 0..PIX_DIV-1; ce_pix is the wrap tick delayed one cycle.
   always_ff @(posedge CLK_VIDEO or posedge reset) begin
      if (reset) begin
         div_cnt_r <= DIV_ZERO;
         ce_pix_r  <= 1'b0;
      end else begin
         if (tick_s) begin
            div_cnt_r <= DIV_ZERO;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
         end
         ce_pix_r <= tick_s;
      end
   end

   // Next position: restart on line/frame edges, otherwise count up and stick at all-ones.
   always_comb begin
      hcount_nxt_s = hcount_r;
      vcount_nxt_s = vcount_r;
      if (hs_rise_s) begin
         hcount_nxt_s = CNT_ZERO;
         if (vs_rise_s) begin
            vcount_nxt_s = CNT_ZERO;
         end else if (vcount_r != CNT_MAX) begin
            vcount_nxt_s = vcount_r + CNT_ONE;
         end else begin
            vcount_nxt_s = vcount_r;
         end
      end else if (hcount_r != CNT_MAX) begin
         hcount_nxt_s = hcount_r + CNT_ONE;
      end else begin
         hcount_nxt_s = hcount_r;
      end
   end

   // Lock qualification: a frame length must repeat before the mixer gets active video.
   always_comb begin
      state_nxt_s   = state_r;
      match_nxt_s   = match_r;
      ref_len_nxt_s = ref_len_r;
      case (state_r)
         SEARCH: begin
            if (vs_rise_s) begin
               state_nxt_s   = MEASURE;
               match_nxt_s   = MATCH_ZERO;
               ref_len_nxt_s = new_len_s;
            end else begin
               state_nxt_s = SEARCH;
            end
         end
         MEASURE: begin
            if (vs_rise_s) begin
               if (new_len_s == ref_len_r) begin
                  match_nxt_s = match_r + MATCH_ONE;
                  if ((match_r + MATCH_ONE) >= MATCH_LAST) begin
                     state_nxt_s = LOCKED;
                  end else begin
                     state_nxt_s = MEASURE;
                  end
               end else begin
                  ref_len_nxt_s = new_len_s;
                  match_nxt_s   = MATCH_ZERO;
               end
            end else if (timeout_s) begin
               state_nxt_s = SEARCH;
            end else begin
               state_nxt_s = MEASURE;
            end
         end
         LOCKED: begin
            if ((vs_rise_s && (new_len_s != ref_len_r)) || (!vs_rise_s && timeout_s)) begin
               state_nxt_s = SEARCH;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         default: begin
            state_nxt_s = SEARCH;
         end
      endcase
   end

   // Blanking is decided from the positions being loaded, and forced while unlocked.
   always_comb begin
      locked_nxt_s = (state_nxt_s == LOCKED);
      hblank_nxt_s = (hcount_nxt_s >= H_END) | (hcount_nxt_s < H_START) | ~locked_nxt_s;
      vblank_nxt_s = (vcount_nxt_s < V_START) | (vcount_nxt_s > V_END) | ~locked_nxt_s;
   end

   // Timing registers: all position, measurement and blank state moves only on the pixel tick.
   always_ff @(posedge CLK_VIDEO or posedge reset) begin
      if (reset) begin
         hsync_r     <= 1'b0;
         vsync_r     <= 1'b0;
         hcount_r    <= CNT_ZERO;
         vcount_r    <= CNT_ZERO;
         line_len_r  <= CNT_ZERO;
         frame_len_r <= CNT_ZERO;
         hblank_r    <= 1'b1;
         vblank_r    <= 1'b1;
      end else if (tick_s) begin
         hsync_r  <= hs_sync_s;
         hcount_r <= hcount_nxt_s;
         vcount_r <= vcount_nxt_s;
         hblank_r <= hblank_nxt_s;
         vblank_r <= vblank_nxt_s;
         if (hs_rise_s) begin
            line_len_r <= line_meas_s;
            vsync_r    <= vs_sync_s;
         end
         if (vs_rise_s) begin
            frame_len_r <= new_len_s;
         end
      end
   end

   // Lock state register, advanced on the pixel tick alongside the counters.
   always_ff @(posedge CLK_VIDEO or posedge reset) begin
      if (reset) begin
         state_r   <= SEARCH;
         match_r   <= MATCH_ZERO;
         ref_len_r <= CNT_ZERO;
         locked_r  <= 1'b0;
      end else if (tick_s) begin
         state_r   <= state_nxt_s;
         match_r   <= match_nxt_s;
         ref_len_r <= ref_len_nxt_s;
         locked_r  <= locked_nxt_s;
      end
   end

   assign ce_pix    = ce_pix_r;
   assign hsync     = hsync_r;
   assign vsync     = vsync_r;
   assign hblank    = hblank_r;
   assign vblank    = vblank_r;
   assign hcount    = hcount_r;
   assign vcount    = vcount_r;
   assign line_len  = line_len_r;
   assign frame_len = frame_len_r;
   assign locked    = locked_r;

endmodule

// File: tb/tb_bally_video_sync.sv
// Randomised self-checking bench: one default-timing instance, one shrunk-timing instance.
module tb_bally_video_sync;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic hs_a = 1'b0, vs_a = 1'b0, hs_b = 1'b0, vs_b = 1'b0;

   logic       ce_a, hsync_a, vsync_a, hblank_a, vblank_a, locked_a;
   logic [8:0] hcount_a, vcount_a, line_len_a, frame_len_a;
   logic       ce_b, hsync_b, vsync_b, hblank_b, vblank_b, locked_b;
   logic [5:0] hcount_b, vcount_b, line_len_b, frame_len_b;

   always #5 clk = ~clk;

   bally_video_sync u_dut_a (
      .CLK_VIDEO(clk), .reset(reset), .hs_in(hs_a), .vs_in(vs_a),
      .ce_pix(ce_a), .hsync(hsync_a), .vsync(vsync_a), .hblank(hblank_a), .vblank(vblank_a),
      .hcount(hcount_a), .vcount(vcount_a), .line_len(line_len_a), .frame_len(frame_len_a),
      .locked(locked_a)
   );

   bally_video_sync #(
      .PIX_DIV(4), .CNT_W(6), .H_ACT_START(4), .H_ACT_END(16),
      .V_ACT_START(2), .V_ACT_END(7), .LOCK_FRAMES(2)
   ) u_dut_b (
      .CLK_VIDEO(clk), .reset(reset), .hs_in(hs_b), .vs_in(vs_b),
      .ce_pix(ce_b), .hsync(hsync_b), .vsync(vsync_b), .hblank(hblank_b), .vblank(vblank_b),
      .hcount(hcount_b), .vcount(vcount_b), .line_len(line_len_b), .frame_len(frame_len_b),
      .locked(locked_b)
   );

   logic sel_b = 1'b0;
   int o_ce, o_hsync, o_vsync, o_hblank, o_vblank, o_hcount, o_vcount, o_line, o_frame, o_locked;
   assign o_ce     = sel_b ? int'(ce_b)        : int'(ce_a);
   assign o_hsync  = sel_b ? int'(hsync_b)     : int'(hsync_a);
   assign o_vsync  = sel_b ? int'(vsync_b)     : int'(vsync_a);
   assign o_hblank = sel_b ? int'(hblank_b)    : int'(hblank_a);
   assign o_vblank = sel_b ? int'(vblank_b)    : int'(vblank_a);
   assign o_hcount = sel_b ? int'(hcount_b)    : int'(hcount_a);
   assign o_vcount = sel_b ? int'(vcount_b)    : int'(vcount_a);
   assign o_line   = sel_b ? int'(line_len_b)  : int'(line_len_a);
   assign o_frame  = sel_b ? int'(frame_len_b) : int'(frame_len_a);
   assign o_locked = sel_b ? int'(locked_b)    : int'(locked_a);

   int checks = 0;
   int errors = 0;
   int pix_idx = 0;

   // Timing of the instance under test.
   int p_div, p_max, p_hs, p_he, p_vs, p_ve, p_lf;

   // Reference model: positions, measurements and the history of frame lengths since lock was lost.
   int m_h, m_v, m_line, m_flen, m_hsync, m_vsync, m_locked;
   int hist[$];

   task automatic chk_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s at pixel %0d: got %0d want %0d", tag, pix_idx, obs, exp);
      end
   endtask

   function automatic bit tail_equal();
      int n;
      n = hist.size();
      if (n < p_lf) return 1'b0;
      for (int i = n - p_lf; i < n; i++) begin
         if (hist[i] != hist[n-1]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_h = 0; m_v = 0; m_line = 0; m_flen = 0;
      m_hsync = 0; m_vsync = 0; m_locked = 0;
      hist.delete();
   endtask

   task automatic check_reset_values(input string tag);
      chk_val({tag, "_ce"},     o_ce, 0);
      chk_val({tag, "_hsync"},  o_hsync, 0);
      chk_val({tag, "_vsync"},  o_vsync, 0);
      chk_val({tag, "_hblank"}, o_hblank, 1);
      chk_val({tag, "_vblank"}, o_vblank, 1);
      chk_val({tag, "_hcount"}, o_hcount, 0);
      chk_val({tag, "_vcount"}, o_vcount, 0);
      chk_val({tag, "_line"},   o_line, 0);
      chk_val({tag, "_frame"},  o_frame, 0);
      chk_val({tag, "_locked"}, o_locked, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      hs_a = 1'b0; vs_a = 1'b0; hs_b = 1'b0; vs_b = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_values("reset");
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One pixel period: hold the inputs, then apply the spec rules to the model and compare.
   task automatic pixel(input bit hs, input bit vs);
      bit hs_rise, vs_rise, timeout;
      int len;
      if (sel_b) begin hs_b = hs; vs_b = vs; end
      else       begin hs_a = hs; vs_a = vs; end
      for (int c = 1; c <= p_div; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk_val("ce_pix", o_ce, (c == p_div) ? 1 : 0);
      end
      len     = 0;
      hs_rise = hs && (m_hsync == 0);
      vs_rise = 1'b0;
      timeout = (m_v == p_max);
      m_hsync = hs;
      if (hs_rise) begin
         m_line  = (m_h + 1) % (p_max + 1);
         vs_rise = vs && (m_vsync == 0);
         m_vsync = vs;
         if (vs_rise) begin
            len    = (m_v + 1) % (p_max + 1);
            m_flen = len;
            m_v    = 0;
         end else begin
            m_v = (m_v < p_max) ? m_v + 1 : p_max;
         end
         m_h = 0;
      end else begin
         m_h = (m_h < p_max) ? m_h + 1 : p_max;
      end
      if (vs_rise) begin
         if (m_locked != 0) begin
            if (len != hist[hist.size()-1]) begin
               hist.delete();
               m_locked = 0;
            end
         end else begin
            hist.push_back(len);
            m_locked = tail_equal() ? 1 : 0;
         end
      end else if (timeout && (hist.size() > 0)) begin
         hist.delete();
         m_locked = 0;
      end
      pix_idx++;
      chk_val("hcount",    o_hcount, m_h);
      chk_val("vcount",    o_vcount, m_v);
      chk_val("line_len",  o_line, m_line);
      chk_val("frame_len", o_frame, m_flen);
      chk_val("hsync",     o_hsync, m_hsync);
      chk_val("vsync",     o_vsync, m_vsync);
      chk_val("locked",    o_locked, m_locked);
      chk_val("hblank",    o_hblank, ((m_h >= p_he) || (m_h < p_hs) || (m_locked == 0)) ? 1 : 0);
      chk_val("vblank",    o_vblank, ((m_v < p_vs) || (m_v > p_ve) || (m_locked == 0)) ? 1 : 0);
   endtask

   task automatic send_line(input int len, input int hsw, input bit vs);
      for (int p = 0; p < len; p++) pixel(p < hsw, vs);
   endtask

   task automatic send_frame(input int nlines, input int len, input int vsw, input int hsw);
      for (int l = 0; l < nlines; l++) send_line(len, hsw, l < vsw);
   endtask

   initial begin
      // Default timing instance.
      sel_b = 1'b0;
      p_div = 16; p_max = 511; p_hs = 34; p_he = 214; p_vs = 25; p_ve = 254; p_lf = 2;
      do_reset();
      repeat (515) pixel(1'b0, 1'b0);
      chk_val("hcount_sat_511", o_hcount, 511);
      chk_val("idle_unlocked", o_locked, 0);
      repeat (3) send_line(228, 1, 1'b0);
      chk_val("line_len_228", o_line, 228);
      send_line(228, $urandom_range(1, 5), 1'b0);
      for (int p = 0; p < 101; p++) pixel(p < 1, 1'b0);
      chk_val("pre_reset_hcount", o_hcount, 100);
      // Asynchronous reset mid-line, away from any clock edge.
      #2 reset = 1'b1;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) send_line(228, 1, 1'b0);
      chk_val("line_len_after_reset", o_line, 228);

      // Shrunk timing instance for frame-level behaviour.
      sel_b = 1'b1;
      p_div = 4; p_max = 63; p_hs = 4; p_he = 16; p_vs = 2; p_ve = 7; p_lf = 2;
      do_reset();
      repeat (4) send_frame(10, 20, 2, 1);
      chk_val("lock_acquired", o_locked, 1);
      chk_val("frame_len_10", o_frame, 10);
      send_frame(11, 20, 2, 1);
      chk_val("lock_held_pre_measure", o_locked, 1);
      send_frame(11, 20, 2, 1);
      chk_val("lock_drop", o_locked, 0);
      chk_val("hblank_forced", o_hblank, 1);
      chk_val("vblank_forced", o_vblank, 1);
      send_frame(11, 20, 2, 1);
      chk_val("measuring", o_locked, 0);
      send_frame(11, 20, 2, 1);
      chk_val("relock", o_locked, 1);
      repeat (80) pixel(1'b0, 1'b0);
      chk_val("hcount_sat_63", o_hcount, 63);
      chk_val("lock_held_idle", o_locked, 1);
      repeat (4) send_frame(10, 20, 2, 1);
      chk_val("relock_after_stop", o_locked, 1);
      send_frame(70, 20, 0, 1);
      chk_val("vcount_sat_63", o_vcount, 63);
      chk_val("timeout_unlock", o_locked, 0);
      repeat (12) begin
         send_frame(($urandom_range(0, 3) == 0) ? 11 : 10, $urandom_range(18, 22),
                    $urandom_range(1, 3), $urandom_range(1, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
